// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_N_DEF  = 16;
  localparam int unsigned PWM_CH_DEF = 4;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned pwm_cw(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: period counter with edge/center counting and
// boundary-latched period and mode.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned N = PWM_N_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  pwm_mode_e    mode_i,
  input  logic [N-1:0] period_i,
  output logic [N-1:0] cnt_o,
  output pwm_dir_e     dir_o,
  output logic         terminal_c_o
);

  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] per_q, per_d;
  logic [N-1:0] cnt_inc;
  pwm_dir_e     dir_q, dir_d;
  pwm_mode_e    mode_q, mode_d;

  assign cnt_inc = cnt_q + N'(1);

  // Last cycle of the current period.
  always_comb begin
    terminal_c_o = 1'b0;
    if (mode_q == PWM_EDGE) begin
      terminal_c_o = (cnt_q == per_q);
    end else begin
      terminal_c_o = (per_q == '0) || ((dir_q == DIR_DOWN) && (cnt_q == N'(1)));
    end
  end

  // Direction flips as the count reaches the peak, so the peak is a down cycle.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    per_d  = per_q;
    mode_d = mode_q;
    if (en_i) begin
      if (terminal_c_o) begin
        cnt_d  = '0;
        dir_d  = DIR_UP;
        per_d  = period_i;
        mode_d = mode_i;
      end else if (mode_q == PWM_EDGE) begin
        cnt_d = cnt_inc;
      end else if (dir_q == DIR_UP) begin
        cnt_d = cnt_inc;
        if (cnt_inc == per_q) begin
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      per_q  <= '0;
      mode_q <= PWM_EDGE;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      per_q  <= per_d;
      mode_q <= mode_d;
    end
  end

  assign cnt_o = cnt_q;
  assign dir_o = dir_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: double-buffered per-channel duty on a shared
// timebase, with a per-channel load handshake and registered outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter  int unsigned N  = PWM_N_DEF,
  parameter  int unsigned CH = PWM_CH_DEF,
  localparam int unsigned CW = pwm_cw(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  pwm_mode_e     mode_in,
  input  logic [N-1:0]  period_in,
  input  logic          ld_valid,
  input  logic [CW-1:0] ld_ch,
  input  logic [N-1:0]  ld_duty,
  output logic          ld_ready,
  output logic [CH-1:0] pulse,
  output logic          eoc
);

  logic [N-1:0]  cnt;
  pwm_dir_e      dir;
  logic          terminal_c;
  logic          boundary_c;
  logic          accept_c;
  logic [CH-1:0] sel_c;

  logic [N-1:0]  shadow_q [CH];
  logic [N-1:0]  shadow_d [CH];
  logic [N-1:0]  duty_q   [CH];
  logic [N-1:0]  duty_d   [CH];
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] pulse_d;
  logic          eoc_d;

  pwm_timebase #(
    .N(N)
  ) u_timebase (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .mode_i       (mode_in),
    .period_i     (period_in),
    .cnt_o        (cnt),
    .dir_o        (dir),
    .terminal_c_o (terminal_c)
  );

  // Out-of-range channel selects decode to nothing, so they are never ready.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      sel_c[i] = (ld_ch == CW'(i));
    end
  end

  assign ld_ready   = |(sel_c & ~pend_q);
  assign accept_c   = ld_valid & ld_ready;
  assign boundary_c = en & terminal_c;

  // Boundary consumes only already-pending shadows; a same-cycle accept lands
  // on a non-pending channel and waits for the following boundary.
  // In the down half the compare is inclusive so high time is exactly 2*duty.
  always_comb begin
    shadow_d = shadow_q;
    duty_d   = duty_q;
    pend_d   = pend_q;
    pulse_d  = '0;
    eoc_d    = boundary_c;
    for (int unsigned i = 0; i < CH; i++) begin
      if (boundary_c && pend_q[i]) begin
        duty_d[i] = shadow_q[i];
        pend_d[i] = 1'b0;
      end
      if (accept_c && sel_c[i]) begin
        shadow_d[i] = ld_duty;
        pend_d[i]   = 1'b1;
      end
      pulse_d[i] = en & ((cnt < duty_q[i]) |
                         ((dir == DIR_DOWN) && (cnt == duty_q[i])));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        shadow_q[i] <= '0;
        duty_q[i]   <= '0;
      end
      pend_q <= '0;
      pulse  <= '0;
      eoc    <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        duty_q[i]   <= duty_d[i];
      end
      pend_q <= pend_d;
      pulse  <= pulse_d;
      eoc    <= eoc_d;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with a period-position reference model checked
// every cycle, plus hand-computed window counts and latencies.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  pwm_mode_e     mode_in;
  logic [N-1:0]  period_in;
  logic          ld_valid;
  logic [CW-1:0] ld_ch;
  logic [N-1:0]  ld_duty;
  logic          ld_ready;
  logic [CH-1:0] pulse;
  logic          eoc;

  int checks   = 0;
  int failures = 0;

  // Reference model: position k within a period of length L.
  bit            mvalid = 1'b0;
  int            mk, mp;
  pwm_mode_e     mm;
  int            mduty   [CH];
  int            mshadow [CH];
  bit            mpend   [CH];
  logic [CH-1:0] e_pulse;
  logic          e_eoc;

  int m_cnt [CH];
  int m_eoc_n;
  int duty1 [4] = '{0, 3, 10, 255};

  pwm_multi #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode_in   (mode_in),
    .period_in (period_in),
    .ld_valid  (ld_valid),
    .ld_ch     (ld_ch),
    .ld_duty   (ld_duty),
    .ld_ready  (ld_ready),
    .pulse     (pulse),
    .eoc       (eoc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_len(input int p, input pwm_mode_e m);
    if (m == PWM_EDGE) return p + 1;
    return (p == 0) ? 1 : 2 * p;
  endfunction

  // Edge: high for the first d positions. Center: also the last d positions.
  function automatic bit m_high(input int k, input int d, input int p, input pwm_mode_e m);
    if (m == PWM_EDGE || p == 0) return k < d;
    return (k < d) || (k >= 2 * p - d);
  endfunction

  initial begin : compare
    bit er, term, acc;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        er = (32'(ld_ch) < CH) && !mpend[ld_ch];
        chk("pulse", 32'(pulse), 32'(e_pulse));
        chk("eoc", 32'(eoc), 32'(e_eoc));
        chk("ld_ready", 32'(ld_ready), 32'(er));
      end
      // Advance the model using the inputs the coming posedge will sample.
      if (!rst) begin
        mvalid = 1'b1;
        mk = 0; mp = 0; mm = PWM_EDGE;
        for (int i = 0; i < CH; i++) begin
          mduty[i] = 0; mshadow[i] = 0; mpend[i] = 1'b0;
        end
        e_pulse = '0;
        e_eoc   = 1'b1;
      end else if (mvalid) begin
        term = (mk == m_len(mp, mm) - 1);
        for (int i = 0; i < CH; i++) e_pulse[i] = en && m_high(mk, mduty[i], mp, mm);
        e_eoc = en && term;
        acc = ld_valid && (32'(ld_ch) < CH) && !mpend[ld_ch];
        if (en && term) begin
          mk = 0; mp = int'(period_in); mm = mode_in;
          for (int i = 0; i < CH; i++) begin
            if (mpend[i]) begin mduty[i] = mshadow[i]; mpend[i] = 1'b0; end
          end
        end else if (en) begin
          mk++;
        end
        if (acc) begin
          mshadow[ld_ch] = int'(ld_duty);
          mpend[ld_ch]   = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic measure(input int nc);
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    m_eoc_n = 0;
    repeat (nc) begin
      @(negedge clk); #1;
      for (int c = 0; c < CH; c++) m_cnt[c] += int'(pulse[c]);
      m_eoc_n += int'(eoc);
    end
  endtask

  task automatic wait_eoc(output int n);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (eoc !== 1'b1 && n < 64);
    if (eoc !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_eoc timeout actual=%0d cycles without eoc t=%0t", n, $time);
    end
  endtask

  initial begin : stim
    int n;
    rst = 1'b0; en = 1'b0; mode_in = PWM_EDGE; period_in = '0;
    ld_valid = 1'b0; ld_ch = '0; ld_duty = '0;
    cyc(3);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_eoc", 32'(eoc), 32'd1);

    // 1: EDGE P=9, duties {0,3,10,255}
    for (int c = 0; c < 4; c++) begin
      cyc(1); ld_valid = 1'b1; ld_ch = CW'(c); ld_duty = N'(duty1[c]);
    end
    cyc(1); ld_valid = 1'b0; period_in = N'(9); mode_in = PWM_EDGE; en = 1'b1;
    cyc(2); measure(10);
    chk("t1_ch0", 32'(m_cnt[0]), 32'd0);
    chk("t1_ch1", 32'(m_cnt[1]), 32'd3);
    chk("t1_ch2", 32'(m_cnt[2]), 32'd10);
    chk("t1_ch3", 32'(m_cnt[3]), 32'd10);
    chk("t1_eoc", 32'(m_eoc_n), 32'd1);

    // 2: CENTER P=8, ch1 duty 4
    wait_eoc(n);
    cyc(1); mode_in = PWM_CENTER; period_in = N'(8);
    ld_valid = 1'b1; ld_ch = CW'(1); ld_duty = N'(4);
    cyc(1); ld_valid = 1'b0;
    cyc(12); measure(16);
    chk("t2_ch0", 32'(m_cnt[0]), 32'd0);
    chk("t2_ch1", 32'(m_cnt[1]), 32'd8);
    chk("t2_ch2", 32'(m_cnt[2]), 32'd16);
    chk("t2_ch3", 32'(m_cnt[3]), 32'd16);
    chk("t2_eoc", 32'(m_eoc_n), 32'd1);

    // 3: two loads to ch2 in one period
    wait_eoc(n);
    cyc(3); ld_valid = 1'b1; ld_ch = CW'(2); ld_duty = N'(5);
    cyc(1); ld_duty = N'(7);
    @(negedge clk); #1;
    chk("t3_busy", 32'(ld_ready), 32'd0);
    wait_eoc(n);
    chk("t3_ready", 32'(ld_ready), 32'd1);
    cyc(1); ld_valid = 1'b0;
    measure(16);
    chk("t3_ch2", 32'(m_cnt[2]), 32'd10);

    // 4: load ch3 on the terminal cycle
    wait_eoc(n);
    cyc(15); ld_valid = 1'b1; ld_ch = CW'(3); ld_duty = N'(3);
    cyc(1); ld_valid = 1'b0;
    wait_eoc(n);
    chk("t4_eoc_gap", 32'(n), 32'd1);
    chk("t4_busy", 32'(ld_ready), 32'd0);
    measure(16);
    chk("t4_ch3_old", 32'(m_cnt[3]), 32'd16);
    chk("t4_eoc", 32'(m_eoc_n), 32'd1);
    chk("t4_ready", 32'(ld_ready), 32'd1);
    measure(16);
    chk("t4_ch3_new", 32'(m_cnt[3]), 32'd6);

    // 5: 7-cycle stall at cnt 3 of an EDGE P=9 period, period change to 4
    cyc(1); mode_in = PWM_EDGE; period_in = N'(9);
    wait_eoc(n);
    cyc(3); en = 1'b0; period_in = N'(4);
    @(negedge clk);
    measure(6);
    chk("t5_stall_pulse", 32'(m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3]), 32'd0);
    chk("t5_stall_eoc", 32'(m_eoc_n), 32'd0);
    cyc(1); en = 1'b1;
    wait_eoc(n);
    chk("t5_resume", 32'(n), 32'd8);
    wait_eoc(n);
    chk("t5_newp", 32'(n), 32'd5);

    // 6: reset mid-period with pending loads
    cyc(1); ld_valid = 1'b1; ld_ch = CW'(0); ld_duty = N'(2);
    cyc(1); ld_ch = CW'(1); ld_duty = N'(6);
    cyc(1); ld_valid = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_pend", 32'(ld_ready), 32'd0);
    cyc(1); rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_pulse", 32'(pulse), 32'd0);
    chk("t6_eoc", 32'(eoc), 32'd1);
    for (int c = 0; c < 4; c++) begin
      cyc(1); ld_ch = CW'(c);
      @(negedge clk); #1;
      chk("t6_ready", 32'(ld_ready), 32'd1);
    end
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
